mux_scanner: RTL
================

# mux_scanner

Sequencer that sits directly upstream of the 16:1 select multiplexer. It steps the 4-bit select through channels 0..15 and waits a programmable settle time on each channel. It then samples the multiplexer output, assembles the 16 samples into one word and hands the word downstream on a valid/ready handshake.

## Interface
- `SETTLE`, default 2: idle cycles between a select change and the sample of that channel; legal range 0..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin one scan; sampled only in IDLE.
- `mux_out`  in  1  output of the 16:1 multiplexer for the current `sel`.
- `sel`  out  4  channel select driven to the multiplexer's S input.
- `data`  out  16  scanned word; bit i = `mux_out` sampled while `sel`==i.
- `valid`  out  1  `data` holds a complete, unconsumed scan.
- `ready`  in  1  downstream accepts `data` when `valid`&&`ready` at a clock edge.
- `busy`  out  1  scan in progress or result pending.

## Operation
- Registers: state, `sel` (4b), settle counter (4b), shadow word (16b), `data` (16b), `valid`.
- Reset drives state=IDLE, `sel`=0, counter=0, shadow=0, `data`=0, `valid`=0 and `busy`=0.
- Reset applies in every state. It aborts a scan in progress, and any partial word is discarded.
- IDLE, with `busy`=0 and `sel`=0:
  - `start`=1 → SETTLE, or → SAMPLE directly if `SETTLE`==0.
  - The counter loads `SETTLE`-1 on this transition.
- SETTLE:
  - The counter decrements each cycle.
  - When the counter reads 0, the next state is SAMPLE.
  - `sel` is held constant.
- SAMPLE, lasting exactly one cycle:
  - shadow[`sel`] ← `mux_out`.
  - If `sel`≠15: `sel` ← `sel`+1, counter ← `SETTLE`-1, then → SETTLE (or → SAMPLE if `SETTLE`==0).
  - If `sel`==15: `data` ← shadow with bit 15 replaced by the current `mux_out`, `valid` ← 1, `sel` ← 0, then → HOLD.
- HOLD:
  - `data` and `valid` are stable.
  - `valid`&&`ready` at an edge → `valid` ← 0, then → IDLE (see Configuration).
  - `data` keeps the last word after the handshake until the next scan completes.
- `start` is ignored in every state except IDLE and is not queued.
- `busy`=1 in SETTLE, SAMPLE and HOLD.
- `data` never changes while `valid`=1.

## Timing
- Per channel: `SETTLE`+1 cycles. Full scan: 16·(`SETTLE`+1) cycles.
- The scan is counted from the edge where `start` is accepted.
  - The first cycle with `sel`=0 in SETTLE/SAMPLE is the cycle after that edge.
  - `valid` rises on the edge that ends the sample of channel 15.
- Example at `SETTLE`=2: `start` accepted at edge 0, `valid`=1 after edge 48.
- `sel` changes only on the edge that leaves SAMPLE, so `mux_out` is stable for `SETTLE`+1 cycles before it is sampled.
- `ready` may be held high before `valid` rises. The handshake then completes on the first edge with `valid`=1, and `valid` is high for exactly one cycle.
- Back-to-back scans: the earliest next `start` is accepted in the IDLE cycle after the handshake.

## Configuration
- Macro: `MUX_SCANNER_CONTINUOUS_EN`.
- Defined:
  - The handshake in HOLD goes → SETTLE on `sel`=0 (or SAMPLE if `SETTLE`==0), not → IDLE.
  - Scanning repeats without `start` after the first `start`; `busy` stays 1.
  - Only `rst` returns the block to IDLE.
- Undefined: one scan per accepted `start`, as described in Operation.

## Test plan
- Reset mid-scan:
  - Stimulus: `SETTLE`=2, `start` at cycle 5, `rst` at cycle 20.
  - Response: the next cycle shows `sel`=0, `valid`=0, `busy`=0, `data`=0. No `valid` follows without a new `start`.
- Basic scan:
  - Stimulus: `SETTLE`=2, channel pattern 16'hA5C3 on the mux model, `start` pulse, `ready`=1.
  - Response: `valid` is high for one cycle 48 cycles after `start`, with `data`=16'hA5C3. `sel` steps 0..15, holding 3 cycles each.
- Back-pressure:
  - Stimulus: pattern 16'h0001, `ready`=0 for 10 cycles after `valid`, a second `start` during HOLD.
  - Response: `data`=16'h0001 and `valid`=1 are held steady. The `start` is ignored. IDLE follows the `ready` edge.
- Zero settle:
  - Stimulus: `SETTLE`=0, pattern 16'hFFFF.
  - Response: `sel` advances every cycle, `valid` rises 16 cycles after `start`, and `data`=16'hFFFF.
- Settle correctness:
  - Stimulus: the mux model drives X/garbage for the first `SETTLE` cycles after each `sel` change, then true data 16'h3C5A.
  - Response: `data`=16'h3C5A.
- Continuous (macro defined):
  - Stimulus: one `start`, pattern changed from 16'h1234 to 16'h4321 after the first handshake.
  - Response: the first two words are 16'h1234 and 16'h4321, with no idle gap and no second `start`.

Source files
------------

// File: rtl/mux_scanner.sv
// mux_scanner: steps a 4-bit select through channels 0..15 in front of a
// 16:1 multiplexer. On each channel it waits SETTLE idle cycles and then
// samples the multiplexer output for one cycle. The 16 samples form one word,
// which is offered downstream on a valid/ready handshake.
//
// Optional feature: define MUX_SCANNER_CONTINUOUS_EN to rescan immediately
// after every handshake instead of returning to IDLE. Only rst stops it.
module mux_scanner #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mux_out,
    input  logic        ready,
    output logic [3:0]  sel,
    output logic [15:0] data,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // Counter reload for a new channel. With no settle time the counter is
    // never consulted, so zero is loaded instead of letting SETTLE-1 wrap.
    localparam logic [3:0] CNT_RELOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    // First state spent on a freshly selected channel.
    localparam state_t CH_FIRST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;

    // State register: all sequential state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= 4'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 16'd0;
            data_q   <= 16'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic: channel sequencing, settle countdown and word capture.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = CH_FIRST;
                    sel_d   = 4'd0;
                    cnt_d   = CNT_RELOAD;
                end
            end

            S_SETTLE: begin
                // sel is left untouched so the mux output can settle.
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_SAMPLE: begin
                shadow_d[sel_q] = mux_out;
                if (sel_q != 4'd15) begin
                    sel_d   = sel_q + 4'd1;
                    cnt_d   = CNT_RELOAD;
                    state_d = CH_FIRST;
                end else begin
                    // Bit 15 bypasses the shadow so the word is complete
                    // on the same edge that ends the last sample.
                    data_d  = {mux_out, shadow_q[14:0]};
                    valid_d = 1'b1;
                    sel_d   = 4'd0;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
`ifdef MUX_SCANNER_CONTINUOUS_EN
                    sel_d   = 4'd0;
                    cnt_d   = CNT_RELOAD;
                    state_d = CH_FIRST;
`else
                    state_d = S_IDLE;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: registered values straight out, busy decoded from state.
    always_comb begin
        sel   = sel_q;
        data  = data_q;
        valid = valid_q;
        busy  = (state_q != S_IDLE);
    end

endmodule
